// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its environment: program counter
// control, program-memory read port and the decoder-facing instruction stream.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              pc_load;
  logic              pc_enable;
  logic [ADDR_W-1:0] pc_addr_in;
  logic [ADDR_W-1:0] pc_addr;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;

  modport master (
    output pc_load, pc_enable, pc_addr_in,
    input  pc_addr,
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr_data, instr_addr,
    input  instr_ready
  );

  modport slave (
    input  pc_load, pc_enable, pc_addr_in,
    output pc_addr,
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr_data, instr_addr,
    output instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives an external program counter, reads program
// memory with req/ack, and hands bytes to the decoder over valid/ready.
module fetch_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              fault,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] S_BOOT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_REDIRECT = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  localparam int               CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  logic [2:0]        state,      state_d;
  logic              jmp_pend,   jmp_pend_d;
  logic [ADDR_W-1:0] jmp_tgt,    jmp_tgt_d;
  logic [CNT_W-1:0]  wait_cnt,   wait_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] iaddr_q,    iaddr_d;
  logic [DATA_W-1:0] idata_q,    idata_d;
  logic              fault_q,    fault_d;

  logic pc_load_w;
  logic jump_take;

  // Strobes come from registered state only; reset forces them quiet in the
  // reset cycle itself so a half-finished fetch cannot leak out.
  assign pc_load_w       = !reset && (state == S_BOOT || state == S_REDIRECT);
  assign bus.pc_load     = pc_load_w;
  assign bus.pc_addr_in  = pc_load_w ? jmp_tgt : '0;
  assign bus.pc_enable   = !reset && state == S_FETCH && !jmp_pend;
  assign bus.mem_req     = !reset && state == S_WAIT;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = !reset && state == S_ISSUE && !jmp_pend;
  assign bus.instr_data  = idata_q;
  assign bus.instr_addr  = iaddr_q;
  assign fault           = fault_q;

  assign jump_take = jump_valid && state != S_FAULT;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state;
    jmp_pend_d = jmp_pend;
    jmp_tgt_d  = jmp_tgt;
    wait_cnt_d = wait_cnt;
    mem_addr_d = mem_addr_q;
    iaddr_d    = iaddr_q;
    idata_d    = idata_q;
    fault_d    = fault_q;

    case (state)
      S_BOOT, S_REDIRECT: begin
        state_d    = run ? S_FETCH : S_IDLE;
        jmp_pend_d = 1'b0;
      end
      S_IDLE: begin
        if (jmp_pend || jump_valid) state_d = S_REDIRECT;
        else if (run)               state_d = S_FETCH;
      end
      S_FETCH: begin
        if (jmp_pend) begin
          state_d = S_REDIRECT;
        end else begin
          state_d    = S_WAIT;
          mem_addr_d = bus.pc_addr;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          idata_d    = bus.mem_rdata;
          iaddr_d    = mem_addr_q;
          wait_cnt_d = '0;
          state_d    = (jmp_pend || jump_valid) ? S_REDIRECT : S_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
          if (MAX_WAIT != 0 && wait_cnt == WAIT_LAST) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // A pending jump discards the held byte before the decoder ever sees it.
        if (jmp_pend) begin
          state_d = S_REDIRECT;
        end else if (bus.instr_ready) begin
          if (jump_valid) state_d = S_REDIRECT;
          else            state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // Capture overrides the clear in BOOT/REDIRECT, so a jump arriving while
    // the PC is being loaded still gets its own redirect later.
    if (jump_take) begin
      jmp_pend_d = 1'b1;
      jmp_tgt_d  = jump_addr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= S_BOOT;
      jmp_pend   <= 1'b0;
      jmp_tgt    <= RESET_VEC;
      wait_cnt   <= '0;
      mem_addr_q <= '0;
      iaddr_q    <= '0;
      idata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_d;
      jmp_pend   <= jmp_pend_d;
      jmp_tgt    <= jmp_tgt_d;
      wait_cnt   <= wait_cnt_d;
      mem_addr_q <= mem_addr_d;
      iaddr_q    <= iaddr_d;
      idata_q    <= idata_d;
      fault_q    <= fault_d;
    end
  end

endmodule
